// File: rtl/mpmc11_txn_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_txn_fsm
// Brief    : Per-channel transaction sequencer driving the MIG-style app_* UI
//            through write-data/command or read-command/data phases.
// Revision : 1.0  initial release
// ============================================================================
module mpmc11_txn_fsm #(
    parameter int BURSTW  = 3,
    parameter int TOW     = 10,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [BURSTW-1:0] i_burst_len,
    input  logic              i_app_rdy,
    input  logic              i_app_wdf_rdy,
    input  logic              i_app_rd_data_valid,
    output logic [2:0]        o_state,
    output logic              o_app_en,
    output logic [2:0]        o_app_cmd,
    output logic              o_app_wdf_wren,
    output logic              o_app_wdf_end,
    output logic [BURSTW-1:0] o_beat_cnt,
    output logic              o_rd_beat,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRESET1     = 3'd1,
        ST_WRITE_DATA0 = 3'd2,
        ST_WRITE_DATA3 = 3'd3,
        ST_READ_DATA0  = 3'd4,
        ST_READ_DATA1  = 3'd5,
        ST_WAIT_NACK   = 3'd6
    } mpmc11_state_t;

    localparam logic [2:0]        c_CMD_WR   = 3'b000;
    localparam logic [2:0]        c_CMD_RD   = 3'b001;
    localparam logic [BURSTW-1:0] c_BEAT_ONE = BURSTW'(1);
    localparam logic [TOW-1:0]    c_TMO_ONE  = TOW'(1);
    localparam logic [TOW-1:0]    c_TMO_LAST = TOW'(TIMEOUT - 1);

    mpmc11_state_t     r_state;
    mpmc11_state_t     w_state_nxt;
    logic [BURSTW-1:0] r_beat_cnt;
    logic [BURSTW-1:0] w_beat_nxt;
    logic [BURSTW-1:0] r_len;
    logic [BURSTW-1:0] w_len_nxt;
    logic [TOW-1:0]    r_tmo;
    logic [TOW-1:0]    w_tmo_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_rd_beat;
    logic              w_rd_beat_nxt;
    logic              w_last;

    assign w_last = (r_beat_cnt == r_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_len      <= '0;
            r_tmo      <= '0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_rd_beat  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_len      <= w_len_nxt;
            r_tmo      <= w_tmo_nxt;
            r_we       <= w_we_nxt;
            r_err      <= w_err_nxt;
            r_rd_beat  <= w_rd_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat_cnt;
        w_len_nxt     = r_len;
        w_tmo_nxt     = r_tmo;
        w_we_nxt      = r_we;
        w_err_nxt     = r_err;
        w_rd_beat_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_state_nxt = ST_PRESET1;
                    w_we_nxt    = i_we;
                    w_len_nxt   = i_burst_len;
                    w_beat_nxt  = '0;
                    w_err_nxt   = 1'b0;
                    w_tmo_nxt   = '0;
                end
            end
            ST_PRESET1: begin
                w_state_nxt = r_we ? ST_WRITE_DATA0 : ST_READ_DATA0;
            end
            ST_WRITE_DATA0: begin
                if (i_app_wdf_rdy) begin
                    if (w_last) begin
                        w_state_nxt = ST_WRITE_DATA3;
                    end else begin
                        w_beat_nxt = r_beat_cnt + c_BEAT_ONE;
                    end
                end
            end
            ST_WRITE_DATA3: begin
                if (i_app_rdy) begin
                    w_state_nxt = ST_WAIT_NACK;
                end
            end
            ST_READ_DATA0: begin
                if (i_app_rdy) begin
                    w_state_nxt = ST_READ_DATA1;
                    w_beat_nxt  = '0;
                    w_tmo_nxt   = '0;
                end
            end
            ST_READ_DATA1: begin
                // A returning beat takes priority over the timeout terminal count.
                if (i_app_rd_data_valid) begin
                    w_rd_beat_nxt = 1'b1;
                    w_tmo_nxt     = '0;
                    if (w_last) begin
                        w_state_nxt = ST_WAIT_NACK;
                    end else begin
                        w_beat_nxt = r_beat_cnt + c_BEAT_ONE;
                    end
                end else if (r_tmo == c_TMO_LAST) begin
                    w_state_nxt = ST_WAIT_NACK;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + c_TMO_ONE;
                end
            end
            ST_WAIT_NACK: begin
                if (!i_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore decode: outputs depend on registered state only.
    always_comb begin
        o_state        = r_state;
        o_app_en       = (r_state == ST_WRITE_DATA3) || (r_state == ST_READ_DATA0);
        o_app_cmd      = (r_state == ST_READ_DATA0) ? c_CMD_RD : c_CMD_WR;
        o_app_wdf_wren = (r_state == ST_WRITE_DATA0);
        o_app_wdf_end  = (r_state == ST_WRITE_DATA0) && w_last;
        o_beat_cnt     = r_beat_cnt;
        o_rd_beat      = r_rd_beat;
        o_done         = (r_state == ST_WAIT_NACK);
        o_err          = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_mpmc11_txn_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpmc11_txn_fsm
// Brief    : Transaction-level reference bench for mpmc11_txn_fsm.
// Revision : 1.0  initial release
// ============================================================================
module tb_mpmc11_txn_fsm;

    localparam int BURSTW  = 3;
    localparam int TOW     = 5;
    localparam int TIMEOUT = 24;

    localparam int S_IDLE = 0;
    localparam int S_PRE  = 1;
    localparam int S_WD0  = 2;
    localparam int S_WD3  = 3;
    localparam int S_RD0  = 4;
    localparam int S_RD1  = 5;
    localparam int S_WN   = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic              i_we;
    logic [BURSTW-1:0] i_burst_len;
    logic              i_app_rdy;
    logic              i_app_wdf_rdy;
    logic              i_app_rd_data_valid;
    logic [2:0]        o_state;
    logic              o_app_en;
    logic [2:0]        o_app_cmd;
    logic              o_app_wdf_wren;
    logic              o_app_wdf_end;
    logic [BURSTW-1:0] o_beat_cnt;
    logic              o_rd_beat;
    logic              o_done;
    logic              o_err;

    mpmc11_txn_fsm #(
        .BURSTW (BURSTW),
        .TOW    (TOW),
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .i_req              (i_req),
        .i_we               (i_we),
        .i_burst_len        (i_burst_len),
        .i_app_rdy          (i_app_rdy),
        .i_app_wdf_rdy      (i_app_wdf_rdy),
        .i_app_rd_data_valid(i_app_rd_data_valid),
        .o_state            (o_state),
        .o_app_en           (o_app_en),
        .o_app_cmd          (o_app_cmd),
        .o_app_wdf_wren     (o_app_wdf_wren),
        .o_app_wdf_end      (o_app_wdf_end),
        .o_beat_cnt         (o_beat_cnt),
        .o_rd_beat          (o_rd_beat),
        .o_done             (o_done),
        .o_err              (o_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected view of the current cycle, maintained by the transaction tasks.
    int e_state = S_IDLE;
    int e_beat  = 0;
    int e_len   = 0;
    bit e_err   = 1'b0;
    bit e_rd_beat = 1'b0;
    bit pend_rd = 1'b0;
    bit chk_en  = 1'b0;

    int n_en = 0, n_rd1 = 0, n_rdbeat = 0, n_done = 0, n_end = 0, n_wd0 = 0;
    int unsigned hist[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", int'(o_state), e_state);
            check("beat_cnt", int'(o_beat_cnt), e_beat);
            check("app_en", int'(o_app_en), int'(e_state == S_WD3 || e_state == S_RD0));
            if (e_state == S_WD3) check("app_cmd_wr", int'(o_app_cmd), 0);
            if (e_state == S_RD0) check("app_cmd_rd", int'(o_app_cmd), 1);
            check("wdf_wren", int'(o_app_wdf_wren), int'(e_state == S_WD0));
            check("wdf_end", int'(o_app_wdf_end), int'(e_state == S_WD0 && e_beat == e_len));
            check("rd_beat", int'(o_rd_beat), int'(e_rd_beat));
            check("done", int'(o_done), int'(e_state == S_WN));
            check("err", int'(o_err), int'(e_err));
            n_en     += int'(o_app_en);
            n_rd1    += int'(o_state == 3'(S_RD1));
            n_rdbeat += int'(o_rd_beat);
            n_done   += int'(o_done);
            n_end    += int'(o_app_wdf_end);
            n_wd0    += int'(o_app_wdf_wren);
            hist.push_back(32'(o_state));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        e_rd_beat = pend_rd;
        pend_rd   = 1'b0;
    endtask

    // Randomize every input that the current phase is supposed to ignore.
    task automatic noise();
        i_we                = 1'($urandom);
        i_burst_len         = BURSTW'($urandom);
        i_app_rdy           = 1'($urandom);
        i_app_wdf_rdy       = 1'($urandom);
        i_app_rd_data_valid = 1'($urandom);
    endtask

    function automatic bit roll(input int pct, input int waited, input int stall);
        return (waited >= stall) && (($urandom % 100) < pct);
    endfunction

    // vmode: 0 random, 1 every other cycle, 2 never, 3 only on the last cycle before timeout
    task automatic txn(input bit wr, input int len, input int pct, input int wstall,
                       input int cstall, input int vmode, input int hold, input bit drop);
        int  b;
        int  idle;
        int  waited;
        bit  ok;
        noise();
        i_req = 1'b1;
        i_we = wr;
        i_burst_len = BURSTW'(len);
        step();
        e_state = S_PRE; e_beat = 0; e_len = len; e_err = 1'b0;
        noise();
        if (drop) i_req = 1'($urandom);
        step();
        if (wr) begin
            e_state = S_WD0;
            for (b = 0; b <= len; b++) begin
                e_beat = b;
                waited = 0;
                do begin
                    noise();
                    if (drop) i_req = 1'($urandom);
                    ok = roll(pct, waited, (b == 0) ? wstall : 0);
                    i_app_wdf_rdy = ok;
                    waited++;
                    step();
                end while (!ok);
            end
            e_state = S_WD3;
            e_beat  = len;
            waited  = 0;
            do begin
                noise();
                if (drop) i_req = 1'($urandom);
                ok = roll(pct, waited, cstall);
                i_app_rdy = ok;
                waited++;
                step();
            end while (!ok);
            e_state = S_WN;
        end else begin
            e_state = S_RD0;
            waited  = 0;
            do begin
                noise();
                if (drop) i_req = 1'($urandom);
                ok = roll(pct, waited, cstall);
                i_app_rdy = ok;
                waited++;
                step();
            end while (!ok);
            e_state = S_RD1; e_beat = 0; b = 0; idle = 0;
            while (e_state == S_RD1) begin
                noise();
                if (drop) i_req = 1'($urandom);
                case (vmode)
                    0:       ok = (($urandom % 100) < pct);
                    1:       ok = (idle == 1);
                    2:       ok = 1'b0;
                    default: ok = (idle == TIMEOUT - 1);
                endcase
                i_app_rd_data_valid = ok;
                pend_rd = ok;
                step();
                if (ok) begin
                    idle = 0;
                    if (b == len) e_state = S_WN;
                    else begin b++; e_beat = b; end
                end else begin
                    idle++;
                    if (idle == TIMEOUT) begin e_state = S_WN; e_err = 1'b1; end
                end
            end
        end
        for (int h = 0; h < hold; h++) begin
            noise();
            i_req = 1'b1;
            step();
        end
        noise();
        i_req = 1'b0;
        step();
        e_state = S_IDLE;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            noise();
            i_req = 1'b0;
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int s_en, s_rd1, s_rb, s_done, s_end, s_wd0;
        int exp_t1[9];
        exp_t1 = '{0, 1, 2, 2, 2, 2, 3, 6, 0};
        rst = 1'b1;
        i_req = 1'b0;
        noise();
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", int'(o_state), S_IDLE);
        check("rst_beat", int'(o_beat_cnt), 0);
        check("rst_app_en", int'(o_app_en), 0);
        check("rst_wren", int'(o_app_wdf_wren), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_err", int'(o_err), 0);
        check("rst_rd_beat", int'(o_rd_beat), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle_cycles(2);

        // Write len=3 with all ready: exact state trace and one wdf_end.
        base = hist.size();
        s_end = n_end;
        txn(1'b1, 3, 100, 0, 0, 0, 0, 1'b0);
        idle_cycles(1);
        for (int i = 0; i < 9; i++) check("t1_trace", int'(hist[base + i]), exp_t1[i]);
        check("t1_wdf_end_cnt", n_end - s_end, 1);

        // Write len=1 with data and command stalls.
        s_en = n_en; s_wd0 = n_wd0;
        txn(1'b1, 1, 100, 2, 3, 0, 0, 1'b0);
        check("t2_app_en_cycles", n_en - s_en, 4);
        check("t2_wd0_cycles", n_wd0 - s_wd0, 4);
        idle_cycles(1);

        // Read len=7, valid every other cycle.
        s_rb = n_rdbeat;
        txn(1'b0, 7, 100, 0, 0, 1, 0, 1'b0);
        check("t3_rd_beats", n_rdbeat - s_rb, 8);
        check("t3_err", int'(o_err), 0);
        idle_cycles(1);

        // Read len=0 that never returns data: timeout after exactly TIMEOUT cycles.
        s_rd1 = n_rd1;
        txn(1'b0, 0, 100, 0, 0, 2, 0, 1'b0);
        check("t4_rd1_cycles", n_rd1 - s_rd1, TIMEOUT);
        check("t4_err", int'(o_err), 1);
        idle_cycles(1);

        // Beats on the terminal-count cycle are counted; done held with req.
        s_done = n_done; s_rb = n_rdbeat;
        txn(1'b0, 1, 100, 0, 0, 3, 5, 1'b0);
        check("t5_err", int'(o_err), 0);
        check("t5_rd_beats", n_rdbeat - s_rb, 2);
        check("t5_done_cycles", n_done - s_done, 6);
        idle_cycles(1);

        // Asynchronous reset during write beat 2.
        noise();
        i_req = 1'b1; i_we = 1'b1; i_burst_len = 3'd3;
        step();
        e_state = S_PRE; e_beat = 0; e_len = 3; e_err = 1'b0;
        noise();
        step();
        e_state = S_WD0;
        for (int k = 1; k <= 2; k++) begin
            noise();
            i_app_wdf_rdy = 1'b1;
            step();
            e_beat = k;
        end
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_state", int'(o_state), S_IDLE);
        check("t6_beat", int'(o_beat_cnt), 0);
        check("t6_wren", int'(o_app_wdf_wren), 0);
        check("t6_done", int'(o_done), 0);
        @(posedge clk);
        #1;
        i_req = 1'b0;
        rst = 1'b0;
        e_state = S_IDLE; e_beat = 0; e_len = 0; e_err = 1'b0;
        chk_en = 1'b1;
        idle_cycles(1);
        txn(1'b1, 3, 100, 0, 0, 0, 0, 1'b0);
        idle_cycles(1);

        // Randomized traffic, including ignored req drops mid-transaction.
        for (int t = 0; t < 60; t++) begin
            txn(1'($urandom), int'($urandom_range(7, 0)), int'($urandom_range(100, 30)),
                int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'($urandom));
            idle_cycles(int'($urandom_range(2, 0)));
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
